// File: rtl/adc_reader_pkg.sv
// adc_reader_pkg: shared FSM state type, default frame geometry and sizing helper for adc_serial_reader
package adc_reader_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;
  function automatic int clog2_min1(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  localparam int DEF_DATA_W = 12;
  localparam int DEF_LEAD_BITS = 2;
  localparam int DEF_CLK_DIV = 2;
  localparam int DEF_CS_SETUP = 2;
  localparam int DEF_CS_HIGH = 4;
  localparam int NB = DEF_LEAD_BITS + DEF_DATA_W;
  localparam int BIT_CNT_W = $clog2(NB + 1);
  localparam int DIV_CNT_W = clog2_min1(DEF_CLK_DIV);
  localparam int FRAME_CYCLES = 1 + DEF_CS_SETUP + NB * 2 * DEF_CLK_DIV - 1;
endpackage

// File: rtl/adc_serial_reader_sclk_divider.sv
// sclk_divider: SCLK generator with a sample tick in the last cycle of each high half
//   clk, rst_n : system clock, async active-low reset
//   en         : run request, driven with the next-cycle shift condition so SCLK falls on shift entry
//   sclk       : registered serial clock, held high whenever not running
//   tick       : 1-cycle pulse in the final clk cycle of each SCLK-high half
module sclk_divider #(
  parameter int CLK_DIV = 2,
  parameter int W = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sclk,
  output logic tick
);
  localparam logic [W-1:0] TOP = W'(CLK_DIV - 1);
  logic [W-1:0] cnt;
  logic on;
  // idling at TOP with sclk high makes the first enabled edge a falling SCLK edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= TOP;
      sclk <= 1'b1;
      on <= 1'b0;
    end else begin
      on <= en;
      if (!en) begin
        cnt <= TOP;
        sclk <= 1'b1;
      end else if (cnt == TOP) begin
        cnt <= '0;
        sclk <= ~sclk;
      end else
        cnt <= cnt + 1'b1;
    end
  assign tick = on & sclk & (cnt == TOP);
endmodule

// File: rtl/adc_serial_reader.sv
// adc_serial_reader: SPI-style ADC reader that drops lead bits and presents one sample per frame
//   clk_50M    : system clock
//   locked     : async active-low reset
//   start      : frame request, honoured only in IDLE
//   SDO        : ADC serial data, MSB first after LEAD_BITS null bits
//   CS, SCLK   : ADC chip select (active-low) and serial clock (idles high)
//   busy       : frame in progress
//   data_out   : last completed sample, data_valid pulses once when it updates
module adc_serial_reader
  import adc_reader_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEAD_BITS = DEF_LEAD_BITS,
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int CS_SETUP = DEF_CS_SETUP,
  parameter int CS_HIGH = DEF_CS_HIGH
) (
  input  logic              clk_50M,
  input  logic              locked,
  input  logic              start,
  input  logic              SDO,
  output logic              CS,
  output logic              SCLK,
  output logic              busy,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid
);
  localparam int FNB = LEAD_BITS + DATA_W;
  localparam int BW = $clog2(FNB + 1);
  localparam int DW = clog2_min1(CLK_DIV);
  localparam int WW = clog2_min1(CS_SETUP > CS_HIGH ? CS_SETUP : CS_HIGH);
  state_t state, nxt;
  logic [BW-1:0] bcnt;
  logic [WW-1:0] wcnt;
  logic [DATA_W-1:0] shreg, sh_nxt;
  logic tick, armed, last;
  sclk_divider #(.CLK_DIV(CLK_DIV), .W(DW)) u_div (
    .clk(clk_50M),
    .rst_n(locked),
    .en(nxt == SHIFT),
    .sclk(SCLK),
    .tick(tick)
  );
  always_comb begin
    last = tick && bcnt == BW'(FNB - 1);
    sh_nxt = DATA_W'({shreg, SDO});
    nxt = state == IDLE  ? (start && armed ? SETUP : IDLE) :
          state == SETUP ? (wcnt == WW'(CS_SETUP - 1) ? SHIFT : SETUP) :
          state == SHIFT ? (last ? HOLD : SHIFT) :
                           (wcnt == WW'(CS_HIGH - 1) ? IDLE : HOLD);
  end
  // armed blocks a start seen on the very first edge after reset release
  always_ff @(posedge clk_50M or negedge locked)
    if (!locked) begin
      state <= IDLE;
      armed <= 1'b0;
      bcnt <= '0;
      wcnt <= '0;
      shreg <= '0;
      CS <= 1'b1;
      busy <= 1'b0;
      data_out <= '0;
      data_valid <= 1'b0;
    end else begin
      armed <= 1'b1;
      state <= nxt;
      wcnt <= (nxt != state || state == IDLE || state == SHIFT) ? '0 : wcnt + 1'b1;
      bcnt <= nxt != state ? '0 : bcnt + BW'(tick);
      if (tick && bcnt >= BW'(LEAD_BITS)) shreg <= sh_nxt;
      CS <= !(nxt == SETUP || nxt == SHIFT);
      busy <= nxt != IDLE;
      data_valid <= last;
      if (last) data_out <= sh_nxt;
    end
endmodule

// File: tb/tb_adc_serial_reader.sv
// tb_adc_serial_reader: directed self-checking bench with a serial ADC model
module tb_adc_serial_reader;
  logic clk_50M = 0, locked = 0, start = 0, SDO = 1;
  logic CS, SCLK, busy, data_valid;
  logic [11:0] data_out;
  int checks = 0, errors = 0, cyc = 0, nvalid = 0, dv2 = 0, sviol = 0, falls = 0, fcnt = 0, run = 0;
  logic [13:0] frame = 0;
  logic pv = 0, pcs = 1, ps = 1, seg = 0;

  adc_serial_reader dut (
    .clk_50M(clk_50M), .locked(locked), .start(start), .SDO(SDO),
    .CS(CS), .SCLK(SCLK), .busy(busy), .data_out(data_out), .data_valid(data_valid)
  );

  always #10 clk_50M = ~clk_50M;
  always @(posedge clk_50M) cyc <= cyc + 1;

  // ADC: next frame bit appears on each SCLK fall while selected
  always @(negedge SCLK or posedge CS)
    if (CS) fcnt = 0;
    else begin
      if (fcnt < 14) SDO = frame[13-fcnt];
      fcnt++;
      falls++;
    end

  always @(negedge clk_50M) begin
    if (data_valid) nvalid++;
    if (data_valid && pv) dv2++;
    pv = data_valid;
    if (locked && CS && pcs && SCLK !== ps) sviol++;
    if (SCLK !== ps) begin
      if (seg && locked && run != 2) sviol++;
      seg = locked && !CS;
      run = 1;
    end else run++;
    if (!locked || CS) seg = 0;
    ps = SCLK;
    pcs = CS;
  end

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk_50M);
      #1;
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int i = 1; i <= 200; i++) begin
      tick_n(1);
      if (data_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && busy; i++) tick_n(1);
    tick_n(1);
  endtask

  task automatic test_reset();
    tick_n(2);
    checks++; if (CS !== 1'b1) begin errors++; $display("FAIL reset_cs got %b want 1", CS); end
    checks++; if (SCLK !== 1'b1) begin errors++; $display("FAIL reset_sclk got %b want 1", SCLK); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (data_out !== 12'h000) begin errors++; $display("FAIL reset_data got %h want 000", data_out); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", data_valid); end
    start = 1;
    locked = 1;
    tick_n(1);
    start = 0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_at_unlock got busy=%b want 0", busy); end
    tick_n(2);
  endtask

  task automatic test_single();
    int lat;
    frame = {2'b11, 12'hA5C};
    falls = 0;
    start = 1;
    tick_n(1);
    start = 0;
    checks++; if (busy !== 1'b1 || CS !== 1'b0) begin errors++; $display("FAIL single_accept got busy=%b cs=%b want 1 0", busy, CS); end
    wait_valid(lat);
    checks++; if (lat != 58) begin errors++; $display("FAIL single_latency got %0d want 58", lat); end
    checks++; if (data_out !== 12'hA5C) begin errors++; $display("FAIL single_data got %h want a5c", data_out); end
    checks++; if (falls != 14) begin errors++; $display("FAIL single_falls got %0d want 14", falls); end
    tick_n(1);
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL single_pulse got %b want 0", data_valid); end
    checks++; if (data_out !== 12'hA5C) begin errors++; $display("FAIL single_hold got %h want a5c", data_out); end
    wait_idle();
  endtask

  task automatic test_order();
    int lat;
    frame = {2'b00, 12'hFFF};
    start = 1;
    tick_n(1);
    start = 0;
    wait_valid(lat);
    checks++; if (data_out !== 12'hFFF || lat != 58) begin errors++; $display("FAIL order_fff got %h lat %0d want fff lat 58", data_out, lat); end
    wait_idle();
    frame = {2'b11, 12'h000};
    start = 1;
    tick_n(1);
    start = 0;
    wait_valid(lat);
    checks++; if (data_out !== 12'h000 || lat != 58) begin errors++; $display("FAIL order_000 got %h lat %0d want 000 lat 58", data_out, lat); end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    int v[3];
    int nv = 0, cs_hi = 0;
    frame = {2'b01, 12'h3C5};
    start = 1;
    for (int i = 1; i <= 250; i++) begin
      tick_n(1);
      if (data_valid) begin
        v[nv] = i;
        nv++;
        if (nv == 3) break;
      end
      if (nv == 1 && CS) cs_hi++;
    end
    start = 0;
    checks++; if (nv != 3) begin errors++; $display("FAIL b2b_count got %0d want 3", nv); end
    checks++; if (v[1] - v[0] != 63) begin errors++; $display("FAIL b2b_period1 got %0d want 63", v[1] - v[0]); end
    checks++; if (v[2] - v[1] != 63) begin errors++; $display("FAIL b2b_period2 got %0d want 63", v[2] - v[1]); end
    checks++; if (cs_hi != 5) begin errors++; $display("FAIL b2b_cs_high got %0d want 5", cs_hi); end
    checks++; if (data_out !== 12'h3C5) begin errors++; $display("FAIL b2b_data got %h want 3c5", data_out); end
    wait_idle();
  endtask

  task automatic test_ignore();
    int n0, vl, bl;
    frame = {2'b10, 12'h5A3};
    n0 = nvalid;
    vl = -1;
    bl = 0;
    start = 1;
    tick_n(1);
    start = 0;
    for (int i = 1; i <= 80; i++) begin
      tick_n(1);
      start = (i == 9 || i == 29);
      if (data_valid) vl = i;
      if (vl < 0 && !busy) bl++;
    end
    start = 0;
    checks++; if (nvalid - n0 != 1) begin errors++; $display("FAIL ignore_count got %0d want 1", nvalid - n0); end
    checks++; if (vl != 58) begin errors++; $display("FAIL ignore_latency got %0d want 58", vl); end
    checks++; if (bl != 0) begin errors++; $display("FAIL ignore_busy got %0d low cycles want 0", bl); end
    checks++; if (data_out !== 12'h5A3) begin errors++; $display("FAIL ignore_data got %h want 5a3", data_out); end
    wait_idle();
  endtask

  task automatic test_reset_mid();
    int n0, lat;
    frame = {2'b11, 12'h0F0};
    start = 1;
    tick_n(1);
    start = 0;
    tick_n(31);
    checks++; if (CS !== 1'b0) begin errors++; $display("FAIL mid_in_shift got cs=%b want 0", CS); end
    n0 = nvalid;
    #2 locked = 0;
    #1;
    checks++; if (CS !== 1'b1 || SCLK !== 1'b1) begin errors++; $display("FAIL mid_abort got cs=%b sclk=%b want 1 1", CS, SCLK); end
    checks++; if (busy !== 1'b0 || data_valid !== 1'b0) begin errors++; $display("FAIL mid_flags got busy=%b valid=%b want 0 0", busy, data_valid); end
    checks++; if (data_out !== 12'h000) begin errors++; $display("FAIL mid_data got %h want 000", data_out); end
    tick_n(5);
    locked = 1;
    tick_n(3);
    checks++; if (nvalid != n0 || data_out !== 12'h000) begin errors++; $display("FAIL mid_no_valid got %0d pulses data %h want 0 000", nvalid - n0, data_out); end
    frame = {2'b00, 12'h9E7};
    start = 1;
    tick_n(1);
    start = 0;
    wait_valid(lat);
    checks++; if (lat != 58 || data_out !== 12'h9E7) begin errors++; $display("FAIL mid_recover got %h lat %0d want 9e7 lat 58", data_out, lat); end
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_order();
    test_back_to_back();
    test_ignore();
    test_reset_mid();
    checks++; if (sviol != 0) begin errors++; $display("FAIL sclk_shape got %0d violations want 0", sviol); end
    checks++; if (dv2 != 0) begin errors++; $display("FAIL valid_double got %0d want 0", dv2); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
